// File: rtl/csr_trap_sequencer_pkg.sv
// Shared types and constants for the user-mode trap sequencer.
// Holds FSM states, CSR addresses and ustatus bit positions.
package csr_trap_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAP_SAVE,
    S_TRAP_STATUS,
    S_TRAP_JUMP,
    S_RET_STATUS,
    S_RET_JUMP
  } state_t;

  localparam logic [11:0] CSR_USTATUS = 12'h000;
  localparam logic [11:0] CSR_UTVEC   = 12'h005;
  localparam logic [11:0] CSR_UEPC    = 12'h041;
  localparam logic [11:0] CSR_UCAUSE  = 12'h042;
  localparam logic [11:0] CSR_UTVAL   = 12'h043;

  localparam int UIE  = 0;
  localparam int UPIE = 4;

  localparam logic [1:0]  UTVEC_VECTORED = 2'b01;
  localparam logic [31:0] INT_CAUSE      = 32'h80000008;

  function automatic logic [31:0] ustatus_on_trap(
    input logic [31:0] s
  );
    logic [31:0] r;
    r       = s;
    r[UPIE] = s[UIE];
    r[UIE]  = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] ustatus_on_ret(
    input logic [31:0] s
  );
    logic [31:0] r;
    r       = s;
    r[UIE]  = s[UPIE];
    r[UPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// Request, CSR-file and control bundle of the trap sequencer.
// slave is the sequencer side, master the pipeline/CSR-file side.
interface csr_trap_sequencer_if;

  logic        iExcValid;
  logic [4:0]  iExcCause;
  logic [31:0] iPC;
  logic [31:0] iExcTval;
  logic        iIntReq;
  logic        iURet;
  logic        iCsrWrReq;
  logic [11:0] iCsrAddr;
  logic [31:0] iCsrWrData;
  logic [31:0] iUstatus;
  logic [31:0] iUtvec;
  logic [31:0] iUepc;

  logic        oRegWrite;
  logic        oRegWriteSimu;
  logic [11:0] oWriteRegister;
  logic [31:0] oWriteData;
  logic [31:0] oWriteDataUEPC;
  logic [31:0] oWriteDataUCAUSE;
  logic [31:0] oWriteDataUTVAL;
  logic        oCsrGrant;
  logic        oStall;
  logic        oPCRedirect;
  logic [31:0] oPCTarget;

  modport slave (
    input  iExcValid, iExcCause, iPC, iExcTval,
    input  iIntReq, iURet,
    input  iCsrWrReq, iCsrAddr, iCsrWrData,
    input  iUstatus, iUtvec, iUepc,
    output oRegWrite, oRegWriteSimu, oWriteRegister,
    output oWriteData, oWriteDataUEPC,
    output oWriteDataUCAUSE, oWriteDataUTVAL,
    output oCsrGrant, oStall, oPCRedirect, oPCTarget
  );

  modport master (
    output iExcValid, iExcCause, iPC, iExcTval,
    output iIntReq, iURet,
    output iCsrWrReq, iCsrAddr, iCsrWrData,
    output iUstatus, iUtvec, iUepc,
    input  oRegWrite, oRegWriteSimu, oWriteRegister,
    input  oWriteData, oWriteDataUEPC,
    input  oWriteDataUCAUSE, oWriteDataUTVAL,
    input  oCsrGrant, oStall, oPCRedirect, oPCTarget
  );

endinterface

// File: rtl/csr_trap_target.sv
// Trap handler address: utvec base, offset by 4*cause for
// interrupts when utvec selects vectored mode.
module csr_trap_target
  import csr_trap_sequencer_pkg::*;
(
  input  logic [31:0] utvec,
  input  logic [4:0]  cause,
  input  logic        is_int,
  output logic [31:0] target
);

  logic [31:0] base;
  logic [31:0] offs;
  logic        vec;

  assign base = {utvec[31:2], 2'b00};
  assign vec  = (utvec[1:0] == UTVEC_VECTORED) && is_int;
  assign offs = vec ? {25'b0, cause, 2'b00} : 32'b0;
  assign target = base + offs;

endmodule

// File: rtl/csr_trap_sequencer.sv
// User-mode trap/uret sequencer: saves uepc/ucause/utval,
// updates ustatus and redirects the PC over a few cycles.
module csr_trap_sequencer #(
  parameter logic [31:0] INT_CAUSE = csr_trap_sequencer_pkg::INT_CAUSE,
  parameter logic [31:0] RESET_PC  = 32'h00400000
) (
  input logic             iCLK,
  input logic             iRST_N,
  csr_trap_sequencer_if.slave bus
);
  import csr_trap_sequencer_pkg::*;

  state_t      state, nstate;
  logic [31:0] epc_q, cause_q, tval_q;
  logic        int_q;
  logic        take_exc, take_int, take_ret, take_csr;
  logic [31:0] trap_target;

  logic        reg_wr, reg_wr_simu, grant, stall, redir;
  logic [11:0] wr_reg;
  logic [31:0] wr_data, wr_uepc, wr_ucause, wr_utval, pc_tgt;

  assign take_exc = bus.iExcValid;
  assign take_int = !take_exc && bus.iIntReq
                    && bus.iUstatus[UIE];
  assign take_ret = !take_exc && !take_int && bus.iURet;
  assign take_csr = !take_exc && !take_int && !take_ret
                    && bus.iCsrWrReq;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= S_IDLE;
    else         state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: begin
        if (take_exc || take_int) nstate = S_TRAP_SAVE;
        else if (take_ret)        nstate = S_RET_STATUS;
      end
      S_TRAP_SAVE:   nstate = S_TRAP_STATUS;
      S_TRAP_STATUS: nstate = S_TRAP_JUMP;
      S_TRAP_JUMP:   nstate = S_IDLE;
      S_RET_STATUS:  nstate = S_RET_JUMP;
      S_RET_JUMP:    nstate = S_IDLE;
      default:       nstate = S_IDLE;
    endcase
  end

  // Trap context is captured only at acceptance; later requests
  // are held by the requester until the sequencer is back in IDLE.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      epc_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      int_q   <= 1'b0;
    end else if (state == S_IDLE && take_exc) begin
      epc_q   <= bus.iPC;
      cause_q <= {27'b0, bus.iExcCause};
      tval_q  <= bus.iExcTval;
      int_q   <= 1'b0;
    end else if (state == S_IDLE && take_int) begin
      epc_q   <= bus.iPC;
      cause_q <= INT_CAUSE;
      tval_q  <= '0;
      int_q   <= 1'b1;
    end
  end

  csr_trap_target u_target (
    .utvec  (bus.iUtvec),
    .cause  (cause_q[4:0]),
    .is_int (int_q),
    .target (trap_target)
  );

  always_comb begin
    reg_wr      = 1'b0;
    reg_wr_simu = 1'b0;
    grant       = 1'b0;
    stall       = 1'b0;
    redir       = 1'b0;
    wr_reg      = '0;
    wr_data     = '0;
    wr_uepc     = '0;
    wr_ucause   = '0;
    wr_utval    = '0;
    pc_tgt      = RESET_PC;
    if (iRST_N) begin
      unique case (state)
        S_IDLE: begin
          stall = take_exc || take_int || take_ret;
          if (take_csr) begin
            grant   = 1'b1;
            reg_wr  = 1'b1;
            wr_reg  = bus.iCsrAddr;
            wr_data = bus.iCsrWrData;
          end
        end
        S_TRAP_SAVE: begin
          stall       = 1'b1;
          reg_wr_simu = 1'b1;
          wr_uepc     = epc_q;
          wr_ucause   = cause_q;
          wr_utval    = tval_q;
        end
        S_TRAP_STATUS: begin
          stall   = 1'b1;
          reg_wr  = 1'b1;
          wr_reg  = CSR_USTATUS;
          wr_data = ustatus_on_trap(bus.iUstatus);
        end
        S_TRAP_JUMP: begin
          stall  = 1'b1;
          redir  = 1'b1;
          pc_tgt = trap_target;
        end
        S_RET_STATUS: begin
          stall   = 1'b1;
          reg_wr  = 1'b1;
          wr_reg  = CSR_USTATUS;
          wr_data = ustatus_on_ret(bus.iUstatus);
        end
        S_RET_JUMP: begin
          stall  = 1'b1;
          redir  = 1'b1;
          pc_tgt = bus.iUepc;
        end
        default: ;
      endcase
    end
  end

  assign bus.oRegWrite        = reg_wr;
  assign bus.oRegWriteSimu    = reg_wr_simu;
  assign bus.oWriteRegister   = wr_reg;
  assign bus.oWriteData       = wr_data;
  assign bus.oWriteDataUEPC   = wr_uepc;
  assign bus.oWriteDataUCAUSE = wr_ucause;
  assign bus.oWriteDataUTVAL  = wr_utval;
  assign bus.oCsrGrant        = grant;
  assign bus.oStall           = stall;
  assign bus.oPCRedirect      = redir;
  assign bus.oPCTarget        = pc_tgt;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer: exception, interrupt,
// CSR write priority, uret and mid-sequence reset.
module tb_csr_trap_sequencer;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  int   total = 0;
  int   passed = 0;

  csr_trap_sequencer_if bus ();

  csr_trap_sequencer #(
    .INT_CAUSE (32'h80000008),
    .RESET_PC  (32'h00400000)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    bus.iExcValid  = 0; bus.iExcCause = 0;
    bus.iPC        = 0; bus.iExcTval  = 0;
    bus.iIntReq    = 0; bus.iURet     = 0;
    bus.iCsrWrReq  = 0; bus.iCsrAddr  = 0;
    bus.iCsrWrData = 0; bus.iUstatus  = 0;
    bus.iUtvec     = 0; bus.iUepc     = 0;

    #2;
    chk("rst_target", bus.oPCTarget, 32'h00400000);
    chk("rst_stall", {31'b0, bus.oStall}, 0);
    chk("rst_regwr", {31'b0, bus.oRegWrite}, 0);
    cyc(); cyc();
    iRST_N = 1;

    // Exception: cause 2, non-vectored utvec
    cyc();
    bus.iExcValid = 1; bus.iExcCause = 5'd2;
    bus.iPC = 32'h00400010; bus.iExcTval = 32'hDEADBEEF;
    bus.iUstatus = 32'h1; bus.iUtvec = 32'h00400100;
    #1;
    chk("exc_acc_stall", {31'b0, bus.oStall}, 1);
    chk("exc_acc_regwr", {31'b0, bus.oRegWrite}, 0);
    cyc();
    bus.iExcValid = 0; #1;
    chk("exc_simu", {31'b0, bus.oRegWriteSimu}, 1);
    chk("exc_uepc", bus.oWriteDataUEPC, 32'h00400010);
    chk("exc_ucause", bus.oWriteDataUCAUSE, 32'h2);
    chk("exc_utval", bus.oWriteDataUTVAL, 32'hDEADBEEF);
    chk("exc_simu_regwr", {31'b0, bus.oRegWrite}, 0);
    cyc();
    chk("exc_st_regwr", {31'b0, bus.oRegWrite}, 1);
    chk("exc_st_simu", {31'b0, bus.oRegWriteSimu}, 0);
    chk("exc_st_reg", {20'b0, bus.oWriteRegister}, 0);
    chk("exc_st_data", bus.oWriteData, 32'h10);
    chk("exc_st_nored", {31'b0, bus.oPCRedirect}, 0);
    cyc();
    chk("exc_redir", {31'b0, bus.oPCRedirect}, 1);
    chk("exc_target", bus.oPCTarget, 32'h00400100);
    cyc();
    chk("exc_idle_redir", {31'b0, bus.oPCRedirect}, 0);
    chk("exc_idle_tgt", bus.oPCTarget, 32'h00400000);
    chk("exc_idle_stall", {31'b0, bus.oStall}, 0);

    // Interrupt, vectored utvec; request drops mid-sequence
    bus.iIntReq = 1; bus.iPC = 32'h00400044;
    bus.iUstatus = 32'h1; bus.iUtvec = 32'h00400101;
    #1;
    chk("int_acc_stall", {31'b0, bus.oStall}, 1);
    cyc();
    bus.iIntReq = 0; #1;
    chk("int_simu", {31'b0, bus.oRegWriteSimu}, 1);
    chk("int_ucause", bus.oWriteDataUCAUSE, 32'h80000008);
    chk("int_utval", bus.oWriteDataUTVAL, 32'h0);
    chk("int_uepc", bus.oWriteDataUEPC, 32'h00400044);
    cyc();
    chk("int_st_data", bus.oWriteData, 32'h10);
    cyc();
    chk("int_redir", {31'b0, bus.oPCRedirect}, 1);
    chk("int_target", bus.oPCTarget, 32'h00400120);
    cyc();
    chk("int_idle_stall", {31'b0, bus.oStall}, 0);

    // Masked interrupt lets a CSR write through
    bus.iUstatus = 32'h0; bus.iIntReq = 1;
    bus.iCsrWrReq = 1; bus.iCsrAddr = 12'h005;
    bus.iCsrWrData = 32'h1234;
    #1;
    chk("csr_grant", {31'b0, bus.oCsrGrant}, 1);
    chk("csr_regwr", {31'b0, bus.oRegWrite}, 1);
    chk("csr_reg", {20'b0, bus.oWriteRegister}, 32'h005);
    chk("csr_data", bus.oWriteData, 32'h1234);
    chk("csr_stall", {31'b0, bus.oStall}, 0);
    cyc();
    chk("csr_notrap", {31'b0, bus.oRegWriteSimu}, 0);
    bus.iIntReq = 0;

    // Exception beats uret and CSR write; uret held until IDLE
    bus.iExcValid = 1; bus.iExcCause = 5'd5;
    bus.iURet = 1; bus.iUstatus = 32'h10;
    bus.iUepc = 32'h00400020; bus.iUtvec = 32'h00400101;
    #1;
    chk("pri_grant", {31'b0, bus.oCsrGrant}, 0);
    chk("pri_regwr", {31'b0, bus.oRegWrite}, 0);
    chk("pri_stall", {31'b0, bus.oStall}, 1);
    cyc();
    bus.iExcValid = 0; #1;
    chk("pri_simu", {31'b0, bus.oRegWriteSimu}, 1);
    chk("pri_ucause", bus.oWriteDataUCAUSE, 32'h5);
    chk("pri_busy_grant", {31'b0, bus.oCsrGrant}, 0);
    cyc();
    chk("pri_st_data", bus.oWriteData, 32'h0);
    cyc();
    chk("pri_target", bus.oPCTarget, 32'h00400100);
    cyc();
    chk("ret_acc_stall", {31'b0, bus.oStall}, 1);
    chk("ret_acc_grant", {31'b0, bus.oCsrGrant}, 0);
    cyc();
    bus.iURet = 0; bus.iCsrWrReq = 0; #1;
    chk("ret_st_regwr", {31'b0, bus.oRegWrite}, 1);
    chk("ret_st_reg", {20'b0, bus.oWriteRegister}, 0);
    chk("ret_st_data", bus.oWriteData, 32'h11);
    cyc();
    chk("ret_redir", {31'b0, bus.oPCRedirect}, 1);
    chk("ret_target", bus.oPCTarget, 32'h00400020);
    cyc();
    chk("ret_idle_redir", {31'b0, bus.oPCRedirect}, 0);

    // Reset asserted during TRAP_STATUS
    bus.iExcValid = 1; bus.iUstatus = 32'h1;
    cyc();
    bus.iExcValid = 0;
    cyc();
    chk("mrst_pre_regwr", {31'b0, bus.oRegWrite}, 1);
    iRST_N = 0; #1;
    chk("mrst_regwr", {31'b0, bus.oRegWrite}, 0);
    chk("mrst_stall", {31'b0, bus.oStall}, 0);
    chk("mrst_target", bus.oPCTarget, 32'h00400000);
    #2;
    iRST_N = 1;
    cyc();
    chk("mrst_nored1", {31'b0, bus.oPCRedirect}, 0);
    chk("mrst_nosimu", {31'b0, bus.oRegWriteSimu}, 0);
    cyc();
    chk("mrst_nored2", {31'b0, bus.oPCRedirect}, 0);
    chk("mrst_idle_stall", {31'b0, bus.oStall}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/csr_trap_sequencer.md
CSR_TRAP_SEQUENCER -- requirements
Module: csr_trap_sequencer

Interface
REQ-001 SHALL have parameter INT_CAUSE, default 32'h80000008, meaning the ucause value written for an external interrupt.
REQ-002 SHALL have parameter RESET_PC, default 32'h00400000, meaning the oPCTarget value in reset and IDLE.
REQ-003 SHALL have one clock and an asynchronous active-low reset: iCLK  in  1  rising-edge clock; iRST_N  in  1  asynchronous active-low reset.
REQ-004 SHALL have inputs: iExcValid 1 synchronous exception request; iExcCause 5 exception code; iPC 32 PC of the faulting/interrupted instruction; iExcTval 32 trap value; iIntReq 1 level interrupt request; iURet 1 uret request.
REQ-005 SHALL have CSR-instruction inputs: iCsrWrReq 1 write request; iCsrAddr 12 CSR address; iCsrWrData 32 write data.
REQ-006 SHALL have CSR-file readback inputs: iUstatus 32, iUtvec 32, iUepc 32.
REQ-007 SHALL have CSR-file drive outputs: oRegWrite 1, oRegWriteSimu 1, oWriteRegister 12, oWriteData 32, oWriteDataUEPC 32, oWriteDataUCAUSE 32, oWriteDataUTVAL 32.
REQ-008 SHALL have control outputs: oCsrGrant 1 CSR write accepted; oStall 1 hold pipeline; oPCRedirect 1 one-cycle PC load; oPCTarget 32 redirect address.

Function
REQ-009 SHALL implement states IDLE, TRAP_SAVE, TRAP_STATUS, TRAP_JUMP, RET_STATUS, RET_JUMP.
REQ-010 IDLE priority, same cycle: iExcValid > (iIntReq & iUstatus[0]) > iURet > iCsrWrReq.
REQ-011 Exception/interrupt accepted in IDLE SHALL latch epc=iPC, cause={27'b0,iExcCause} or INT_CAUSE, tval=iExcTval or 0, and go to TRAP_SAVE.
REQ-012 TRAP_SAVE SHALL assert oRegWriteSimu for exactly one cycle with latched epc/cause/tval on the UEPC/UCAUSE/UTVAL outputs.
REQ-013 TRAP_STATUS SHALL assert oRegWrite, oWriteRegister=12'h000, oWriteData=iUstatus with bit4=iUstatus[0], bit0=0.
REQ-014 TRAP_JUMP SHALL pulse oPCRedirect with target {iUtvec[31:2],2'b00}, plus 4*cause[4:0] when iUtvec[1:0]==2'b01 and the trap is an interrupt; next state IDLE.
REQ-015 iURet in IDLE SHALL go RET_STATUS: oRegWrite to 12'h000, data iUstatus with bit0=iUstatus[4], bit4=1; then RET_JUMP: oPCRedirect, target iUepc; then IDLE.
REQ-016 Trap latency: accept at cycle N, UEPC/UCAUSE/UTVAL write at N+1, ustatus at N+2, redirect at N+3; uret redirect at N+2.
REQ-017 CSR write SHALL be combinational in IDLE only when no higher-priority request: oCsrGrant=oRegWrite=1, oWriteRegister=iCsrAddr, oWriteData=iCsrWrData.
REQ-018 oStall SHALL be 1 in every non-IDLE state and in the IDLE cycle a trap/uret is accepted.
REQ-019 Requests arriving while not IDLE SHALL be ignored (requester holds them); iIntReq deasserting mid-sequence SHALL not abort it.
REQ-020 oRegWrite and oRegWriteSimu SHALL never be asserted in the same cycle.
REQ-021 Inactive data outputs SHALL be 0; oPCTarget SHALL be RESET_PC when oPCRedirect is 0.

Reset
REQ-022 iRST_N low SHALL asynchronously force IDLE, clear latched epc/cause/tval, and drive all outputs 0 except oPCTarget=RESET_PC, including mid-sequence.
REQ-023 First state change after release SHALL occur at the first rising iCLK with iRST_N high.

Structure
REQ-024 Shared package SHALL hold state enumeration, CSR addresses (USTATUS 12'h000, UTVEC 12'h005, UEPC 12'h041, UCAUSE 12'h042, UTVAL 12'h043), ustatus bit indices UIE=0/UPIE=4, and INT_CAUSE.
REQ-025 One sub-module csr_trap_target SHALL compute the TRAP_JUMP target combinationally.

Verification
REQ-026 iExcValid, cause 2, iPC 32'h00400010, tval 32'hDEADBEEF, iUstatus 32'h1 -> Simu write cycle 1, ustatus 32'h10 cycle 2, redirect to iUtvec 32'h00400100 cycle 3.
REQ-027 iIntReq with iUstatus 32'h1, iUtvec 32'h00400101 -> ucause 32'h80000008, utval 0, target 32'h00400120.
REQ-028 iIntReq with iUstatus 0 plus iCsrWrReq addr 12'h005 data 32'h1234 -> no trap, oCsrGrant=1, write to 12'h005.
REQ-029 iExcValid and iURet and iCsrWrReq same cycle -> trap taken, no grant, uret ignored; iURet after IDLE, iUstatus 32'h10, iUepc 32'h00400020 -> ustatus 32'h11, redirect 32'h00400020.
REQ-030 iRST_N low during TRAP_STATUS -> immediate IDLE, oRegWrite 0, no redirect after release.
